// File: rtl/load_store_unit.sv
// RV32I memory stage with an internal little-endian data RAM.
// Each accepted access takes WAIT_CYCLES+2 stalled cycles, followed by a one-cycle done pulse.
module load_store_unit #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUout,
  input  logic [31:0] RD2,
  output logic        stall,
  output logic        done,
  output logic [31:0] ReadData,
  output logic        fault
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_next;
  logic [3:0]        count;
  logic [ADDR_W+1:0] lat_addr;
  logic [31:0]       lat_data;
  logic [2:0]        lat_funct3;
  logic              lat_write;
  logic [31:0]       mem [DEPTH_WORDS];

  logic        request, illegal, accept, access_now;
  logic [3:0]  byte_en;
  logic [31:0] wdata, rd_word, rd_shift, load_value;
  logic        unused_addr_bits;

  // Address bits above the RAM size alias and are deliberately dropped.
  assign unused_addr_bits = ^ALUout[31:ADDR_W+2];

  assign request = MemRead | MemWrite;

  always_comb begin
    illegal = 1'b0;
    if (MemRead && MemWrite) illegal = 1'b1;
    if (MemRead && (funct3 == 3'b011 || funct3[2:1] == 2'b11)) illegal = 1'b1;
    if (MemWrite && (funct3[2] || funct3 == 3'b011)) illegal = 1'b1;
    if (funct3[1:0] == 2'b01 && ALUout[0]) illegal = 1'b1;
    if (funct3[1:0] == 2'b10 && ALUout[1:0] != 2'b00) illegal = 1'b1;
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    done       = 1'b0;
    fault      = 1'b0;
    accept     = 1'b0;
    access_now = 1'b0;
    case (state)
      IDLE: begin
        if (request) begin
          if (illegal) begin
            fault = 1'b1;
          end else begin
            accept     = 1'b1;
            stall      = 1'b1;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (count == 4'd0) begin
          access_now = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Reset wins over everything, including aborting a pending store.
    if (rst) begin
      stall      = 1'b0;
      done       = 1'b0;
      fault      = 1'b0;
      accept     = 1'b0;
      access_now = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= 4'd0;
      ReadData <= 32'd0;
    end else begin
      state <= state_next;
      if (accept) begin
        count <= 4'(WAIT_CYCLES);
      end else if (state == BUSY && count != 4'd0) begin
        count <= count - 4'd1;
      end
      if (access_now && !lat_write) ReadData <= load_value;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_addr   <= ALUout[ADDR_W+1:0];
      lat_data   <= RD2;
      lat_funct3 <= funct3;
      lat_write  <= MemWrite;
    end
  end

  always_comb begin
    byte_en = 4'b1111;
    wdata   = lat_data;
    case (lat_funct3[1:0])
      2'b00: begin
        byte_en = 4'b0001 << lat_addr[1:0];
        wdata   = {4{lat_data[7:0]}};
      end
      2'b01: begin
        byte_en = lat_addr[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{lat_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (access_now && lat_write) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) mem[lat_addr[ADDR_W+1:2]][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  assign rd_word  = mem[lat_addr[ADDR_W+1:2]];
  assign rd_shift = rd_word >> {lat_addr[1:0], 3'b000};

  always_comb begin
    load_value = rd_word;
    case (lat_funct3)
      3'b000:  load_value = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_value = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_value = {24'd0, rd_shift[7:0]};
      3'b101:  load_value = {16'd0, rd_shift[15:0]};
      default: load_value = rd_word;
    endcase
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage directly downstream of the execute stage (register file + ALU).
- Consumes ALUout as the byte address and RD2 as the store data. Performs RV32I loads and stores (byte, half, word) against an internal little-endian data RAM.
- Returns sign- or zero-extended ReadData to the writeback mux.
- Has a configurable wait-state counter. Asserts stall to freeze PC and upstream state while an access is in flight.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the data RAM (power of two)
WAIT_CYCLES, 0, extra busy cycles per access (0..15)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
MemRead  input  1  load request
MemWrite  input  1  store request
funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
ALUout  input  32  byte address from execute stage
RD2  input  32  store data from register file
stall  output  1  hold upstream; combinational
done  output  1  one-cycle pulse: access completed this cycle
ReadData  output  32  extended load result, held until next load completes
fault  output  1  one-cycle pulse: misaligned/illegal request, no access performed

Behaviour:
- Reset
  - On rst, state goes to IDLE.
  - ReadData=0, done=0, fault=0, stall=0, wait counter=0.
  - RAM contents are not cleared.
  - A store whose write edge has not yet occurred is aborted.
- FSM states: IDLE, BUSY, DONE.
- IDLE, no request (MemRead=MemWrite=0): remain IDLE, all pulses low.
- IDLE, request
  - Request is checked combinationally.
  - Fault conditions, any of:
    - MemRead and MemWrite both high.
    - Load funct3 in {011,110,111}.
    - Store funct3 not in {000,001,010}.
    - Half access with ALUout[0]=1.
    - Word access with ALUout[1:0]!=0.
  - Faulting request: fault=1 that cycle, stall=0, stay IDLE, RAM and ReadData unchanged.
  - Valid request: stall=1 combinationally in the same cycle. Latch address, RD2, funct3 and direction. Load counter with WAIT_CYCLES. Go to BUSY.
- BUSY
  - stall=1.
  - If counter!=0: decrement, stay BUSY.
  - If counter==0: perform the access on this edge and go to DONE.
    - Store: writes byte lanes per byte enables.
    - Load: registers the extended result into ReadData.
- DONE
  - stall=0, done=1 for exactly one cycle.
  - Inputs ignored; the same instruction is still presented and retires this cycle.
  - Next state IDLE unconditionally.
- Latency: valid request accepted in cycle 0. stall high for cycles 0..WAIT_CYCLES+1. done high in cycle WAIT_CYCLES+2. Minimum gap between accepted requests is WAIT_CYCLES+3 cycles.
- Byte enables (little-endian)
  - SB: lane ALUout[1:0], data RD2[7:0] replicated.
  - SH: lanes {1,0} or {3,2} by ALUout[1], data RD2[15:0].
  - SW: all lanes.
- Load extraction
  - B/H sign-extend bit 7/15.
  - BU/HU zero-extend.
  - W passes through.
- Addressing: word index = ALUout[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses alias modulo 4*DEPTH_WORDS bytes.
- Stores never modify ReadData.
- Upstream must hold inputs stable while stall=1; the block uses only the values latched at acceptance.
- rst asserted in BUSY or DONE overrides everything that cycle.

Test Plan:
- SW RD2=0xDEADBEEF at 0x10, then LW 0x10 (WAIT_CYCLES=0) -> stall high 2 cycles each, done in 3rd cycle, ReadData=0xDEADBEEF.
- SB RD2=0x00000080 at 0x13, then LB 0x13, LBU 0x13 and LW 0x10 -> ReadData 0xFFFFFF80, 0x00000080, 0x80ADBEEF. LH 0x12 -> 0xFFFF80AD.
- LH at 0x11, LW at 0x12, and MemRead=MemWrite=1 -> fault=1 for one cycle each, stall=0, done=0, RAM and ReadData unchanged.
- WAIT_CYCLES=3: LW -> stall high exactly 5 cycles, done in cycle 6. funct3/ALUout changed mid-BUSY -> result reflects latched values.
- SW 0x12345678 to 0x20 with rst pulsed in first BUSY cycle (WAIT_CYCLES=2) -> all outputs 0, LW 0x20 afterwards returns prior contents.
- DEPTH_WORDS=1024: SW 0xCAFEF00D to 0x1000 -> LW 0x0 returns 0xCAFEF00D.
